// File: rtl/rcn_uart_master.sv
// rcn_uart_master: bridges a UART byte stream to the RCN ring as a bus master.
// A host sends binary command frames. Each frame becomes one single-word RCN
// read or write. The bridge returns an ACK byte, plus four data bytes for reads,
// or a NAK byte.
// Optional feature: define RCN_UART_MASTER_TIMEOUT_EN to add the inter-byte
// timeout and the response timeout.
// Also contains rcn_master, the ring initiator used by the bridge.

`timescale 1ns/1ps

// rcn_master: inserts one request into the ring and strips responses addressed to it.
// Packet: [68] valid, [67] request, [66] wr, [65:60] id, [59:56] mask,
//         [55:34] addr[23:2], [33:32] seq, [31:0] data.
module rcn_master #(
  parameter int MASTER_ID = 0
) (
  input  logic        rst,
  input  logic        clk,
  input  logic [68:0] rcn_in,
  output logic [68:0] rcn_out,
  input  logic        cs,
  input  logic [1:0]  seq,
  output logic        busy,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [21:0] word_addr,
  input  logic [31:0] wdata,
  output logic        rdone,
  output logic        wdone,
  output logic [1:0]  rsp_seq,
  output logic [31:0] rsp_data
);

  localparam logic [5:0] MY_ID = 6'(MASTER_ID);

  logic [68:0] rin;
  logic [68:0] rout;
  logic        my_resp;
  logic        req_valid;
  logic [68:0] req;
  logic        resp_vld;
  logic        resp_wr;
  logic [1:0]  resp_seq;
  logic [31:0] resp_data;

  assign my_resp   = rin[68] && !rin[67] && (rin[65:60] == MY_ID);
  assign busy      = rin[68] && !my_resp;
  assign req_valid = cs && !busy;
  assign req       = {1'b1, 1'b1, wr, MY_ID, mask, word_addr, seq, wdata};
  assign rcn_out   = rout;

  // Ring stage: insert our request into an empty slot, remove our responses, forward the rest.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rin  <= '0;
      rout <= '0;
    end else begin
      rin  <= rcn_in;
      rout <= req_valid ? req : (my_resp ? 69'd0 : rin);
    end
  end

  // Capture the fields of a response addressed to this master for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_vld  <= 1'b0;
      resp_wr   <= 1'b0;
      resp_seq  <= '0;
      resp_data <= '0;
    end else begin
      resp_vld  <= my_resp;
      resp_wr   <= rin[66];
      resp_seq  <= rin[33:32];
      resp_data <= rin[31:0];
    end
  end

  assign rdone    = resp_vld && !resp_wr;
  assign wdone    = resp_vld && resp_wr;
  assign rsp_seq  = resp_seq;
  assign rsp_data = resp_data;

endmodule

module rcn_uart_master #(
  parameter int          MASTER_ID    = 0,
  parameter logic [23:0] BYTE_TIMEOUT = 24'd5000000,
  parameter logic [15:0] RSP_TIMEOUT  = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [68:0] rcn_in,
  output logic [68:0] rcn_out,
  input  logic        rx_vld,
  input  logic [7:0]  rx_data,
  output logic        tx_vld,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        active,
  output logic        rx_overrun
);

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_ISSUE, S_WAIT, S_RSP, S_NAK
  } state_t;

  state_t      state;
  logic        cmd_wr;
  logic [3:0]  cmd_mask;
  logic [21:0] word_addr;   // address bits [23:2]; bits [1:0] are always issued as 0
  logic [31:0] wdata;
  logic [1:0]  byte_cnt;
  logic [1:0]  seq;         // next sequence number to issue
  logic [1:0]  cur_seq;     // sequence number of the outstanding request
  logic [31:0] rdata;
  logic [2:0]  rsp_left;    // data bytes still to send after the current tx byte

  logic        cs;
  logic        busy;
  logic        rdone;
  logic        wdone;
  logic [1:0]  rsp_seq;
  logic [31:0] rsp_data;
  logic        rsp_hit;
  logic        rx_ok;

`ifdef RCN_UART_MASTER_TIMEOUT_EN
  logic [23:0] byte_tmr;
  logic [15:0] rsp_tmr;
`endif

  assign cs      = (state == S_ISSUE) && !busy;
  assign rsp_hit = (rdone || wdone) && (rsp_seq == cur_seq);
  assign rx_ok   = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);

  rcn_master #(.MASTER_ID(MASTER_ID)) u_master (
    .rst       (!rst_n),
    .clk       (clk),
    .rcn_in    (rcn_in),
    .rcn_out   (rcn_out),
    .cs        (cs),
    .seq       (seq),
    .busy      (busy),
    .wr        (cmd_wr),
    .mask      (cmd_mask),
    .word_addr (word_addr),
    .wdata     (wdata),
    .rdone     (rdone),
    .wdone     (wdone),
    .rsp_seq   (rsp_seq),
    .rsp_data  (rsp_data)
  );

  // Frame parser, transaction sequencer and response serializer.
  // NOTE: the asynchronous reset clears every control and datapath register,
  // so the FSM and all outputs reach a known state as soon as rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cmd_wr     <= 1'b0;
      cmd_mask   <= '0;
      word_addr  <= '0;
      wdata      <= '0;
      byte_cnt   <= '0;
      seq        <= '0;
      cur_seq    <= '0;
      rdata      <= '0;
      rsp_left   <= '0;
      tx_vld     <= 1'b0;
      tx_data    <= '0;
      active     <= 1'b0;
      rx_overrun <= 1'b0;
`ifdef RCN_UART_MASTER_TIMEOUT_EN
      byte_tmr   <= '0;
      rsp_tmr    <= '0;
`endif
    end else begin
      rx_overrun <= rx_vld && !rx_ok;
`ifdef RCN_UART_MASTER_TIMEOUT_EN
      // Timers clear unless a state below keeps counting; any transition clears them.
      byte_tmr   <= '0;
      rsp_tmr    <= '0;
`endif
      case (state)
        S_IDLE: begin
          if (rx_vld) begin
            cmd_wr   <= (rx_data[7:4] == OP_WRITE);
            cmd_mask <= rx_data[3:0];
            byte_cnt <= '0;
            active   <= 1'b1;
            if ((rx_data[7:4] == OP_READ) || (rx_data[7:4] == OP_WRITE)) begin
              state <= S_ADDR;
            end else begin
              state   <= S_NAK;
              tx_vld  <= 1'b1;
              tx_data <= NAK_BYTE;
            end
          end
        end

        S_ADDR: begin
          if (rx_vld) begin
            case (byte_cnt)
              2'd0:    word_addr[21:14] <= rx_data;
              2'd1:    word_addr[13:6]  <= rx_data;
              default: word_addr[5:0]   <= rx_data[7:2];
            endcase
            if (byte_cnt == 2'd2) begin
              byte_cnt <= '0;
              state    <= cmd_wr ? S_DATA : S_ISSUE;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
`ifdef RCN_UART_MASTER_TIMEOUT_EN
          else if (byte_tmr == BYTE_TIMEOUT) begin
            state  <= S_IDLE;
            active <= 1'b0;
          end else begin
            byte_tmr <= byte_tmr + 24'd1;
          end
`endif
        end

        S_DATA: begin
          if (rx_vld) begin
            wdata    <= {wdata[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= S_ISSUE;
            end
          end
`ifdef RCN_UART_MASTER_TIMEOUT_EN
          else if (byte_tmr == BYTE_TIMEOUT) begin
            state  <= S_IDLE;
            active <= 1'b0;
          end else begin
            byte_tmr <= byte_tmr + 24'd1;
          end
`endif
        end

        S_ISSUE: begin
          if (!busy) begin
            cur_seq <= seq;
            seq     <= seq + 2'd1;
            state   <= S_WAIT;
          end
`ifdef RCN_UART_MASTER_TIMEOUT_EN
          else if (rsp_tmr == RSP_TIMEOUT) begin
            cur_seq <= seq;
            seq     <= seq + 2'd1;
            state   <= S_NAK;
            tx_vld  <= 1'b1;
            tx_data <= NAK_BYTE;
          end else begin
            rsp_tmr <= rsp_tmr + 16'd1;
          end
`endif
        end

        S_WAIT: begin
          if (rsp_hit) begin
            rdata    <= rsp_data;
            rsp_left <= rdone ? 3'd4 : 3'd0;
            state    <= S_RSP;
            tx_vld   <= 1'b1;
            tx_data  <= ACK_BYTE;
          end
`ifdef RCN_UART_MASTER_TIMEOUT_EN
          else if (rsp_tmr == RSP_TIMEOUT) begin
            state   <= S_NAK;
            tx_vld  <= 1'b1;
            tx_data <= NAK_BYTE;
          end else begin
            rsp_tmr <= rsp_tmr + 16'd1;
          end
`endif
        end

        S_RSP: begin
          if (tx_ready) begin
            if (rsp_left == 3'd0) begin
              tx_vld <= 1'b0;
              state  <= S_IDLE;
              active <= 1'b0;
            end else begin
              tx_data  <= rdata[31:24];
              rdata    <= {rdata[23:0], 8'h00};
              rsp_left <= rsp_left - 3'd1;
            end
          end
        end

        S_NAK: begin
          if (tx_ready) begin
            tx_vld <= 1'b0;
            state  <= S_IDLE;
            active <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          tx_vld <= 1'b0;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule
